// File: rtl/pov_clock_pkg.sv
// ---------------------------------------------------------------------------
// pov_clock_pkg
//   Shared definitions for the POV clock timekeeping and display stages.
//   - DIGIT_W      : width of every digit port handed to the display stage
//   - BCD_W        : width of a raw BCD digit
//   - SEC_MAX, MIN_MAX, HR_MAX : wrap limits of each two-digit field
//   - bcd_pair_t   : tens/ones pair of one two-digit BCD field
//   - bcd_pad()    : zero-extends a raw BCD digit to DIGIT_W
// ---------------------------------------------------------------------------
package pov_clock_pkg;

  localparam int DIGIT_W = 5;
  localparam int BCD_W   = 4;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_pair_t;

  function automatic logic [DIGIT_W-1:0] bcd_pad(input logic [BCD_W-1:0] digit);
    return {{(DIGIT_W - BCD_W){1'b0}}, digit};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
//   Two-digit BCD counter that wraps from MAX_VALUE back to 00. The ones digit
//   wraps at 9 everywhere except at the top value, where both digits wrap.
//   Ports:
//     sys_clk, rst_n : clock, asynchronous active-low reset
//     inc            : advance by one on this edge
//     clr            : force 00 on this edge (wins over inc)
//     carry          : combinational, high when inc is wrapping MAX_VALUE to 00
//     tens, ones     : registered BCD digits
// ---------------------------------------------------------------------------
module bcd_mod_counter
  import pov_clock_pkg::*;
#(
  parameter int MAX_VALUE = 59
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic             carry,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  localparam logic [BCD_W-1:0] TENS_MAX = BCD_W'(MAX_VALUE / 10);
  localparam logic [BCD_W-1:0] ONES_MAX = BCD_W'(MAX_VALUE % 10);

  bcd_pair_t r_q;
  logic      w_at_max;

  assign w_at_max = (r_q.tens == TENS_MAX) && (r_q.ones == ONES_MAX);
  // clr wins, so a cleared field never reports a wrap upstream.
  assign carry    = inc && !clr && w_at_max;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement or block order.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      if (w_at_max) begin
        r_q <= '0;
      end else if (r_q.ones == BCD_W'(9)) begin
        r_q.ones <= '0;
        r_q.tens <= r_q.tens + BCD_W'(1);
      end else begin
        r_q.ones <= r_q.ones + BCD_W'(1);
      end
    end
  end

  assign tens = r_q.tens;
  assign ones = r_q.ones;

endmodule

// File: rtl/bcd_time_counter.sv
// ---------------------------------------------------------------------------
// bcd_time_counter
//   Divides sys_clk into a one-second tick and keeps 24-hour HH:MM:SS time as
//   six BCD digits. Manual pulses advance hours/minutes and zero the seconds.
//   Ports:
//     sys_clk, rst_n          : clock, asynchronous active-low reset
//     run_en                  : high lets time advance, low freezes prescaler
//     inc_hours, inc_minutes  : one increment per cycle sampled high
//     zero_seconds            : clears seconds and the prescaler
//     hours_/minutes_/seconds_ tens/ones : registered BCD digits, 5 bits each
//     sec_tick                : registered one-cycle pulse per prescaler wrap
// ---------------------------------------------------------------------------
module bcd_time_counter
  import pov_clock_pkg::*;
#(
  parameter int CLOCKS_PER_SEC = 50_000_000,
  parameter int PRESCALE_W     = $clog2(CLOCKS_PER_SEC)
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               run_en,
  input  logic               inc_hours,
  input  logic               inc_minutes,
  input  logic               zero_seconds,
  output logic [DIGIT_W-1:0] hours_tens,
  output logic [DIGIT_W-1:0] hours_ones,
  output logic [DIGIT_W-1:0] minutes_tens,
  output logic [DIGIT_W-1:0] minutes_ones,
  output logic [DIGIT_W-1:0] seconds_tens,
  output logic [DIGIT_W-1:0] seconds_ones,
  output logic               sec_tick
);

  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(CLOCKS_PER_SEC - 1);

  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_sec_tick;

  logic      w_wrap;
  logic      w_tick;
  logic      w_sec_carry;
  logic      w_min_inc;
  logic      w_min_carry_raw;
  logic      w_min_carry;
  logic      w_hr_inc;
  logic      w_unused_day_carry;
  bcd_pair_t w_sec;
  bcd_pair_t w_min;
  bcd_pair_t w_hr;

  assign w_wrap = run_en && (r_prescale == PRESCALE_LAST);
  // zero_seconds discards a coinciding tick together with its carry.
  assign w_tick = w_wrap && !zero_seconds;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= '0;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_tick <= w_tick;
      if (zero_seconds) begin
        r_prescale <= '0;
      end else if (run_en) begin
        r_prescale <= w_wrap ? '0 : r_prescale + PRESCALE_W'(1);
      end
    end
  end

  // Carries settle combinationally within one edge, so 23:59:59 -> 00:00:00
  // lands on the same edge as sec_tick. ORing a carry with a manual pulse
  // gives a single increment when both arrive together.
  assign w_min_inc   = w_sec_carry | inc_minutes;
  // A manual minute step never reaches hours, even if it coincides with a
  // seconds carry that wraps 59 -> 00.
  assign w_min_carry = w_min_carry_raw & ~inc_minutes;
  assign w_hr_inc    = w_min_carry | inc_hours;

  bcd_mod_counter #(.MAX_VALUE(SEC_MAX)) u_seconds (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .inc     (w_tick),
    .clr     (zero_seconds),
    .carry   (w_sec_carry),
    .tens    (w_sec.tens),
    .ones    (w_sec.ones)
  );

  bcd_mod_counter #(.MAX_VALUE(MIN_MAX)) u_minutes (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .inc     (w_min_inc),
    .clr     (1'b0),
    .carry   (w_min_carry_raw),
    .tens    (w_min.tens),
    .ones    (w_min.ones)
  );

  // Midnight wrap produces no further carry; the hours carry is not consumed.
  bcd_mod_counter #(.MAX_VALUE(HR_MAX)) u_hours (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .inc     (w_hr_inc),
    .clr     (1'b0),
    .carry   (w_unused_day_carry),
    .tens    (w_hr.tens),
    .ones    (w_hr.ones)
  );

  // Digits come straight from counter flops; padding adds no logic.
  assign hours_tens   = bcd_pad(w_hr.tens);
  assign hours_ones   = bcd_pad(w_hr.ones);
  assign minutes_tens = bcd_pad(w_min.tens);
  assign minutes_ones = bcd_pad(w_min.ones);
  assign seconds_tens = bcd_pad(w_sec.tens);
  assign seconds_ones = bcd_pad(w_sec.ones);
  assign sec_tick     = r_sec_tick;

endmodule

// File: tb/tb_bcd_time_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_time_counter
//   Self-checking bench for bcd_time_counter with CLOCKS_PER_SEC = 4. A
//   reference model keeps the time as plain integers (hours, minutes,
//   seconds, prescaler count) and derives the expected digits arithmetically.
// ---------------------------------------------------------------------------
module tb_bcd_time_counter;

  localparam int CPS = 4;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       run_en;
  logic       inc_hours;
  logic       inc_minutes;
  logic       zero_seconds;
  logic [4:0] hours_tens, hours_ones, minutes_tens, minutes_ones;
  logic [4:0] seconds_tens, seconds_ones;
  logic       sec_tick;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state.
  int m_h, m_m, m_s, m_p;
  bit m_tick;

  bcd_time_counter #(.CLOCKS_PER_SEC(CPS)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .run_en       (run_en),
    .inc_hours    (inc_hours),
    .inc_minutes  (inc_minutes),
    .zero_seconds (zero_seconds),
    .hours_tens   (hours_tens),
    .hours_ones   (hours_ones),
    .minutes_tens (minutes_tens),
    .minutes_ones (minutes_ones),
    .seconds_tens (seconds_tens),
    .seconds_ones (seconds_ones),
    .sec_tick     (sec_tick)
  );

  always #5 sys_clk = ~sys_clk;

  // {tick, HH, MM, SS} with every digit as a 5-bit field.
  function automatic logic [30:0] mk_vec(input bit tick, input int h, input int m, input int s);
    return {tick, 5'(h / 10), 5'(h % 10), 5'(m / 10), 5'(m % 10), 5'(s / 10), 5'(s % 10)};
  endfunction

  function automatic logic [30:0] obs_vec();
    return {sec_tick, hours_tens, hours_ones, minutes_tens, minutes_ones,
            seconds_tens, seconds_ones};
  endfunction

  function automatic logic [30:0] exp_vec();
    return mk_vec(m_tick, m_h, m_m, m_s);
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_p = 0; m_tick = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, settle.
  task automatic step(input bit run, input bit ih, input bit im, input bit zs);
    bit tick, sec_carry, min_carry;
    run_en = run; inc_hours = ih; inc_minutes = im; zero_seconds = zs;
    @(posedge sys_clk);
    tick      = run && (m_p == CPS - 1) && !zs;
    sec_carry = 1'b0;
    min_carry = 1'b0;
    if (zs)       m_p = 0;
    else if (run) m_p = (m_p + 1) % CPS;
    if (zs) m_s = 0;
    else if (tick) begin
      sec_carry = (m_s == 59);
      m_s = (m_s + 1) % 60;
    end
    if (im || sec_carry) begin
      min_carry = sec_carry && !im && (m_m == 59);
      m_m = (m_m + 1) % 60;
    end
    if (ih || min_carry) m_h = (m_h + 1) % 24;
    m_tick = tick;
    #1;
    run_en = 1'b0; inc_hours = 1'b0; inc_minutes = 1'b0; zero_seconds = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  // Reset, then reach h:m:s with the prescaler at CPS-1 (tick due next run cycle).
  task automatic goto_time(input int h, input int m, input int s);
    do_reset();
    repeat (s * CPS) step(1, 0, 0, 0);
    repeat (m) step(0, 0, 1, 0);
    repeat (h) step(0, 1, 0, 0);
    repeat (CPS - 1) step(1, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run_en = 1'b0; inc_hours = 1'b0; inc_minutes = 1'b0; zero_seconds = 1'b0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    n_chk++;
    if (obs_vec() !== mk_vec(0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), mk_vec(0, 0, 0, 0));
    end
    @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_count();
    int ticks = 0;
    for (int c = 0; c < 40; c++) begin
      step(1, 0, 0, 0);
      if (sec_tick === 1'b1) ticks++;
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL basic_count cyc=%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (ticks != 10 || seconds_tens !== 5'd1 || seconds_ones !== 5'd0) begin
      n_err++;
      $display("FAIL basic_count_total: got ticks=%0d sec=%0d%0d expected ticks=10 sec=10",
               ticks, seconds_tens, seconds_ones);
    end
    n_chk++;
    if ({hours_tens[4], hours_ones[4], minutes_tens[4], minutes_ones[4],
         seconds_tens[4], seconds_ones[4]} !== 6'b0) begin
      n_err++;
      $display("FAIL digit_bit4: got a set bit 4, expected all zero");
    end
  endtask

  task automatic test_full_rollover();
    int ticks = 0;
    goto_time(23, 59, 58);
    for (int c = 0; c < 8; c++) begin
      step(1, 0, 0, 0);
      if (sec_tick === 1'b1) begin
        ticks++;
        n_chk++;
        if (ticks == 1 && obs_vec() !== mk_vec(1, 23, 59, 59)) begin
          n_err++;
          $display("FAIL rollover_2359: got %h expected %h", obs_vec(), mk_vec(1, 23, 59, 59));
        end
        if (ticks == 2 && obs_vec() !== mk_vec(1, 0, 0, 0)) begin
          n_err++;
          $display("FAIL rollover_0000: got %h expected %h", obs_vec(), mk_vec(1, 0, 0, 0));
        end
      end
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL rollover cyc=%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (ticks != 2) begin
      n_err++;
      $display("FAIL rollover_ticks: got %0d expected 2", ticks);
    end
  endtask

  task automatic test_carry_vs_inc();
    goto_time(0, 5, 59);
    step(1, 0, 1, 0);
    n_chk++;
    if (obs_vec() !== mk_vec(1, 0, 6, 0)) begin
      n_err++;
      $display("FAIL inc_min_with_carry: got %h expected %h", obs_vec(), mk_vec(1, 0, 6, 0));
    end
    // Minutes carry dropped while inc_minutes is active.
    goto_time(0, 59, 59);
    step(1, 0, 1, 0);
    n_chk++;
    if (obs_vec() !== mk_vec(1, 0, 0, 0)) begin
      n_err++;
      $display("FAIL min_carry_dropped: got %h expected %h", obs_vec(), mk_vec(1, 0, 0, 0));
    end
    // inc_hours coinciding with a minutes carry advances hours once.
    goto_time(0, 59, 59);
    step(1, 1, 0, 0);
    n_chk++;
    if (obs_vec() !== mk_vec(1, 1, 0, 0)) begin
      n_err++;
      $display("FAIL inc_hr_with_carry: got %h expected %h", obs_vec(), mk_vec(1, 1, 0, 0));
    end
  endtask

  task automatic test_zero_vs_tick();
    goto_time(0, 0, 37);
    step(1, 0, 0, 1);
    n_chk++;
    if ({hours_tens, hours_ones, minutes_tens, minutes_ones, seconds_tens, seconds_ones} !== 30'd0) begin
      n_err++;
      $display("FAIL zero_seconds: got %h expected 00:00:00", obs_vec());
    end
    for (int c = 1; c <= 4; c++) begin
      step(1, 0, 0, 0);
      n_chk++;
      if (sec_tick !== (c == 4)) begin
        n_err++;
        $display("FAIL zero_tick_spacing cyc=%0d: got %b expected %b", c, sec_tick, c == 4);
      end
    end
    n_chk++;
    if (obs_vec() !== mk_vec(1, 0, 0, 1)) begin
      n_err++;
      $display("FAIL zero_then_count: got %h expected %h", obs_vec(), mk_vec(1, 0, 0, 1));
    end
  endtask

  task automatic test_freeze();
    do_reset();
    repeat (2) step(1, 0, 0, 0);
    for (int c = 0; c < 100; c++) begin
      step(0, c == 50, 0, 0);
      n_chk++;
      if (obs_vec() !== mk_vec(0, (c >= 50) ? 1 : 0, 0, 0)) begin
        n_err++;
        $display("FAIL freeze cyc=%0d: got %h expected %h", c, obs_vec(),
                 mk_vec(0, (c >= 50) ? 1 : 0, 0, 0));
      end
    end
    for (int c = 1; c <= 2; c++) begin
      step(1, 0, 0, 0);
      n_chk++;
      if (obs_vec() !== mk_vec(c == 2, 1, 0, (c == 2) ? 1 : 0)) begin
        n_err++;
        $display("FAIL resume cyc=%0d: got %h expected %h", c, obs_vec(),
                 mk_vec(c == 2, 1, 0, (c == 2) ? 1 : 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 25; c++) begin
      step(0, 1, 1, 0);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL held_pulse cyc=%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (obs_vec() !== mk_vec(0, 1, 25, 0)) begin
      n_err++;
      $display("FAIL held_pulse_total: got %h expected %h", obs_vec(), mk_vec(0, 1, 25, 0));
    end
  endtask

  task automatic test_random();
    bit run, ih, im, zs;
    goto_time(23, 55, 0);
    for (int c = 0; c < 3000; c++) begin
      run = ($urandom_range(0, 9) != 0);
      ih  = ($urandom_range(0, 29) == 0);
      im  = ($urandom_range(0, 19) == 0);
      zs  = run && ($urandom_range(0, 49) == 0);
      step(run, ih, im, zs);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc=%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    goto_time(12, 34, 56);
    n_chk++;
    if (obs_vec() !== mk_vec(0, 12, 34, 56)) begin
      n_err++;
      $display("FAIL preload_123456: got %h expected %h", obs_vec(), mk_vec(0, 12, 34, 56));
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs_vec() !== mk_vec(0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", obs_vec(), mk_vec(0, 0, 0, 0));
    end
    model_reset();
    @(negedge sys_clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step(1, 0, 0, 0);
      n_chk++;
      if (obs_vec() !== mk_vec(c == 4, 0, 0, (c == 4) ? 1 : 0)) begin
        n_err++;
        $display("FAIL reset_resume cyc=%0d: got %h expected %h", c, obs_vec(),
                 mk_vec(c == 4, 0, 0, (c == 4) ? 1 : 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_full_rollover();
    test_carry_vs_inc();
    test_zero_vs_tick();
    test_freeze();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
